// File: rtl/fsm_param.sv
// fsm_param -- flow-control supervisor for an N-channel FIFO array.
//
// Programs per-FIFO almost-full / almost-empty thresholds while in INIT,
// tracks global idle/active status from the FIFO empty flags and captures
// FIFO errors in a sticky ERROR state that only reset leaves.
//
// Optional feature macro: THR_CHECK_EN
//   defined   : every INIT load checks ae >= af per channel into cfg_err_o;
//               leaving INIT with a failing channel goes to ERROR.
//   undefined : cfg_err_o is tied to 0 and INIT always exits to IDLE.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   init         request/hold initialisation (threshold programming)
//   fifo_errors  per-FIFO error flags
//   fifo_empties per-FIFO empty flags
//   af_i / ae_i  requested thresholds, channel k at [k*THR_W +: THR_W]
//   af_o / ae_o  programmed thresholds driven to the FIFOs
//   error_out    sticky captured FIFO errors
//   cfg_err_o    per-channel threshold-check failure
//   active_out   state == ACTIVE
//   idle_out     state == IDLE
//   state_o      current state encoding
module fsm_param #(
  parameter int NUM_FIFOS   = 8,
  parameter int THR_W       = 4,
  parameter int IDLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_FIFOS-1:0]       fifo_errors,
  input  logic [NUM_FIFOS-1:0]       fifo_empties,
  input  logic [NUM_FIFOS*THR_W-1:0] af_i,
  input  logic [NUM_FIFOS*THR_W-1:0] ae_i,
  output logic [NUM_FIFOS*THR_W-1:0] af_o,
  output logic [NUM_FIFOS*THR_W-1:0] ae_o,
  output logic [NUM_FIFOS-1:0]       error_out,
  output logic [NUM_FIFOS-1:0]       cfg_err_o,
  output logic                       active_out,
  output logic                       idle_out,
  output logic [2:0]                 state_o
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               state, stateNext;
  logic [CNT_W-1:0]     idleCnt, idleCntNext;
  logic [NUM_FIFOS-1:0] errNext;
  logic [NUM_FIFOS-1:0] cfgChk;
  logic                 load;
  logic                 allEmpty, anyErr;

  // Saturating increment: the idle counter must never wrap.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + 1'b1;
  endfunction

  assign allEmpty = &fifo_empties;
  assign anyErr   = |fifo_errors;

`ifdef THR_CHECK_EN
  always_comb begin
    cfgChk = '0;
    for (int k = 0; k < NUM_FIFOS; k++)
      cfgChk[k] = (ae_i[k*THR_W +: THR_W] >= af_i[k*THR_W +: THR_W]);
  end
`else
  assign cfgChk    = '0;
  assign cfg_err_o = '0;
`endif

  // Next-state logic. Priority in INIT/IDLE/ACTIVE:
  // error > init > empties (reset is handled in the register block).
  always_comb begin
    stateNext   = state;
    idleCntNext = idleCnt;
    errNext     = error_out;
    load        = 1'b0;
    case (state)
      S_RESET: begin
        stateNext   = S_INIT;
        idleCntNext = '0;
      end
      S_INIT, S_IDLE, S_ACTIVE: begin
        if (anyErr) begin
          stateNext = S_ERROR;
          errNext   = fifo_errors;
        end else if (init) begin
          stateNext   = S_INIT;
          load        = 1'b1;
          idleCntNext = '0;
        end else if (state == S_INIT) begin
          // The cycle init drops still loads; the check result of this
          // same load decides where INIT exits to.
          load        = 1'b1;
          idleCntNext = '0;
          stateNext   = (|cfgChk) ? S_ERROR : S_IDLE;
        end else if (state == S_IDLE) begin
          idleCntNext = '0;
          if (!allEmpty) stateNext = S_ACTIVE;
        end else begin
          if (!allEmpty) begin
            idleCntNext = '0;
          end else if (idleCnt == CNT_LAST) begin
            stateNext   = S_IDLE;
            idleCntNext = '0;
          end else begin
            idleCntNext = satInc(idleCnt);
          end
        end
      end
      S_ERROR: begin
        errNext = error_out | fifo_errors;
      end
      default: begin
        stateNext   = S_RESET;
        idleCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RESET;
      idleCnt    <= '0;
      error_out  <= '0;
      af_o       <= '0;
      ae_o       <= '0;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
`ifdef THR_CHECK_EN
      cfg_err_o  <= '0;
`endif
    end else begin
      state      <= stateNext;
      idleCnt    <= idleCntNext;
      error_out  <= errNext;
      active_out <= (stateNext == S_ACTIVE);
      idle_out   <= (stateNext == S_IDLE);
      if (load) begin
        af_o <= af_i;
        ae_o <= ae_i;
`ifdef THR_CHECK_EN
        cfg_err_o <= cfgChk;
`endif
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fsm_param.sv
// tb_fsm_param -- directed-vector bench for fsm_param (default parameters:
// 8 FIFOs, 4-bit thresholds, 4 idle cycles). Expectations for the threshold
// check follow THR_CHECK_EN when the bench is built with that macro.
module tb_fsm_param;

  localparam int NF = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [NF-1:0] fifo_errors;
  logic [NF-1:0] fifo_empties;
  logic [NF*TW-1:0] af_i, ae_i, af_o, ae_o;
  logic [NF-1:0] error_out, cfg_err_o;
  logic          active_out, idle_out;
  logic [2:0]    state_o;

  int nVec = 0;
  int nMis = 0;

  fsm_param #(.NUM_FIFOS(NF), .THR_W(TW), .IDLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .fifo_errors  (fifo_errors),
    .fifo_empties (fifo_empties),
    .af_i         (af_i),
    .ae_i         (ae_i),
    .af_o         (af_o),
    .ae_o         (ae_o),
    .error_out    (error_out),
    .cfg_err_o    (cfg_err_o),
    .active_out   (active_out),
    .idle_out     (idle_out),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [2:0] st);
    checkVal({tag, ".state"},  64'(state_o),    64'(st));
    checkVal({tag, ".active"}, 64'(active_out), 64'(st == 3'd3));
    checkVal({tag, ".idle"},   64'(idle_out),   64'(st == 3'd2));
  endtask

  localparam logic [NF*TW-1:0] AF_C   = 32'hCCCC_CCCC;
  localparam logic [NF*TW-1:0] AE_2   = 32'h2222_2222;
  localparam logic [NF*TW-1:0] AF_BAD = 32'hCCCC_6CCC;
  localparam logic [NF*TW-1:0] AE_BAD = 32'h2222_8222;

  initial begin
    // Reset with random inputs held for two cycles.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      init         = 1'($urandom);
      fifo_errors  = NF'($urandom);
      fifo_empties = NF'($urandom);
      af_i         = $urandom;
      ae_i         = $urandom;
      tick();
      checkState("rst", 3'd0);
      checkVal("rst.err", 64'(error_out), 64'h0);
      checkVal("rst.cfg", 64'(cfg_err_o), 64'h0);
      checkVal("rst.af",  64'(af_o), 64'h0);
      checkVal("rst.ae",  64'(ae_o), 64'h0);
    end

    // Release: RESET -> INIT, then thresholds follow inputs while init=1.
    reset = 1'b0; init = 1'b1; fifo_errors = '0; fifo_empties = '1;
    af_i = AF_C; ae_i = AE_2;
    tick();
    checkState("rel1", 3'd1);
    checkVal("rel1.af", 64'(af_o), 64'h0);
    tick();
    checkState("init", 3'd1);
    checkVal("init.af", 64'(af_o), 64'(AF_C));
    checkVal("init.ae", 64'(ae_o), 64'(AE_2));
    init = 1'b0;
    tick();
    checkState("prog", 3'd2);
    checkVal("prog.af",  64'(af_o), 64'(AF_C));
    checkVal("prog.ae",  64'(ae_o), 64'(AE_2));
    checkVal("prog.cfg", 64'(cfg_err_o), 64'h0);

    // Thresholds hold outside INIT.
    af_i = 32'h1111_1111; ae_i = 32'h0;
    tick();
    checkVal("hold.af", 64'(af_o), 64'(AF_C));

    // Debounce: one non-empty cycle enters ACTIVE, interrupted run restarts.
    fifo_empties = 8'hFE; tick(); checkState("dbA", 3'd3);
    fifo_empties = 8'hFF;
    for (int i = 0; i < 3; i++) begin tick(); checkState("db3", 3'd3); end
    fifo_empties = 8'hFE; tick(); checkState("dbBrk", 3'd3);
    fifo_empties = 8'hFF;
    for (int i = 0; i < 3; i++) begin tick(); checkState("db4", 3'd3); end
    tick(); checkState("dbIdle", 3'd2);

    // Error capture from ACTIVE, sticky accumulation, init ignored.
    fifo_empties = 8'hFE; tick(); checkState("eA", 3'd3);
    fifo_errors = 8'h04; tick();
    checkState("e1", 3'd4); checkVal("e1.err", 64'(error_out), 64'h04);
    fifo_errors = 8'h00; tick();
    checkVal("e2.err", 64'(error_out), 64'h04);
    fifo_errors = 8'h10; tick();
    checkVal("e3.err", 64'(error_out), 64'h14);
    fifo_errors = 8'h00; init = 1'b1; tick();
    checkState("eInit", 3'd4);
    checkVal("eInit.err", 64'(error_out), 64'h14);
    checkVal("eInit.af",  64'(af_o), 64'(AF_C));
    init = 1'b0;

    // Simultaneous error and reset: reset wins.
    reset = 1'b1; fifo_errors = 8'hFF; tick();
    checkState("eRst", 3'd0);
    checkVal("eRst.err", 64'(error_out), 64'h0);
    checkVal("eRst.af",  64'(af_o), 64'h0);

    // Back to IDLE, then error + init on the same edge.
    reset = 1'b0; fifo_errors = '0; fifo_empties = '1; init = 1'b1;
    af_i = AF_C; ae_i = AE_2;
    tick(); tick();
    init = 1'b0; tick();
    checkState("pIdle", 3'd2);
    af_i = 32'h5555_5555; fifo_errors = 8'h01; init = 1'b1; tick();
    checkState("prio", 3'd4);
    checkVal("prio.af",  64'(af_o), 64'(AF_C));
    checkVal("prio.err", 64'(error_out), 64'h01);

    // Threshold check: channel 3 has ae >= af.
    reset = 1'b1; fifo_errors = '0; init = 1'b0; tick();
    reset = 1'b0; init = 1'b1; af_i = AF_BAD; ae_i = AE_BAD;
    tick(); tick();
    init = 1'b0; tick();
    checkVal("cfg.af", 64'(af_o), 64'(AF_BAD));
    checkVal("cfg.err", 64'(error_out), 64'h0);
`ifdef THR_CHECK_EN
    checkState("cfg", 3'd4);
    checkVal("cfg.bits", 64'(cfg_err_o), 64'h08);
    reset = 1'b1; tick();
    checkVal("cfgRst.bits", 64'(cfg_err_o), 64'h0);
    reset = 1'b0;
`else
    checkState("cfg", 3'd2);
    checkVal("cfg.bits", 64'(cfg_err_o), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
